// File: rtl/ysyx_22041405_idu_pipe.sv
// Registered RV32I/RV64I decode stage between IFU and EXU.
// Two-entry skid buffer keeps EXU backpressure lossless while in_ready stays registered.
module ysyx_22041405_idu_pipe #(
  parameter int unsigned XLEN       = 64,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_instr,
  input  logic [XLEN-1:0]       in_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       out_pc,
  output logic [5:0]            out_type,
  output logic [XLEN-1:0]       out_imm,
  output logic [ADDR_WIDTH-1:0] out_rs1,
  output logic [ADDR_WIDTH-1:0] out_rs2,
  output logic [ADDR_WIDTH-1:0] out_rd,
  output logic                  out_rf_we,
  output logic                  out_src1_sel,
  output logic                  out_src2_sel,
  output logic [3:0]            out_alu_op,
  output logic                  out_word,
  output logic                  out_illegal,
  output logic                  out_ebreak
);

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpImm32  = 7'b0011011;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpReg    = 7'b0110011;
  localparam logic [6:0] OpReg32  = 7'b0111011;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpSystem = 7'b1110011;

  localparam logic [5:0] TypR = 6'b100000;
  localparam logic [5:0] TypI = 6'b010000;
  localparam logic [5:0] TypS = 6'b001000;
  localparam logic [5:0] TypB = 6'b000100;
  localparam logic [5:0] TypU = 6'b000010;
  localparam logic [5:0] TypJ = 6'b000001;

  localparam logic [3:0] AluAdd   = 4'd0;
  localparam logic [3:0] AluSub   = 4'd1;
  localparam logic [3:0] AluSll   = 4'd2;
  localparam logic [3:0] AluSlt   = 4'd3;
  localparam logic [3:0] AluSltu  = 4'd4;
  localparam logic [3:0] AluXor   = 4'd5;
  localparam logic [3:0] AluSrl   = 4'd6;
  localparam logic [3:0] AluSra   = 4'd7;
  localparam logic [3:0] AluOr    = 4'd8;
  localparam logic [3:0] AluAnd   = 4'd9;
  localparam logic [3:0] AluPassb = 4'd10;

  typedef struct packed {
    logic [XLEN-1:0]       pc;
    logic [5:0]            typ;
    logic [XLEN-1:0]       imm;
    logic [ADDR_WIDTH-1:0] rs1;
    logic [ADDR_WIDTH-1:0] rs2;
    logic [ADDR_WIDTH-1:0] rd;
    logic                  rf_we;
    logic                  src1_sel;
    logic                  src2_sel;
    logic [3:0]            alu_op;
    logic                  word;
    logic                  illegal;
    logic                  ebreak;
  } entry_t;

  // alt selects SUB on func3 000 and SRA on func3 101
  function automatic logic [3:0] f3_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? AluSub : AluAdd;
      3'b001:  return AluSll;
      3'b010:  return AluSlt;
      3'b011:  return AluSltu;
      3'b100:  return AluXor;
      3'b101:  return alt ? AluSra : AluSrl;
      3'b110:  return AluOr;
      default: return AluAnd;
    endcase
  endfunction

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm32;
  logic        illegal;
  logic        shamt6;
  logic        shift_bad;
  logic        r_bad;
  entry_t      dec;

  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];
  assign funct7 = in_instr[31:25];
  assign shamt6 = (XLEN == 64) && (opcode == OpImm);
  // Only SRAI may set bit 30; everything else above the shamt field must be zero
  assign shift_bad = (funct3[1:0] == 2'b01) &
                     (in_instr[31] | (in_instr[30] & ~funct3[2]) | (|in_instr[29:26]) |
                      (in_instr[25] & ~shamt6));
  assign r_bad = !((funct7 == 7'b0000000) ||
                   ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101))));

  always_comb begin
    dec        = '0;
    imm32      = '0;
    illegal    = 1'b0;
    dec.pc     = in_pc;
    dec.rs1    = ADDR_WIDTH'(in_instr[19:15]);
    dec.rs2    = ADDR_WIDTH'(in_instr[24:20]);
    dec.rd     = ADDR_WIDTH'(in_instr[11:7]);
    dec.ebreak = (in_instr == 32'h0010_0073);
    case (opcode)
      OpReg, OpReg32: begin
        dec.typ    = TypR;
        dec.alu_op = f3_op(funct3, in_instr[30]);
        illegal    = r_bad | ((opcode == OpReg32) && (XLEN == 32));
      end
      OpLoad, OpJalr: begin
        dec.typ      = TypI;
        imm32        = {{20{in_instr[31]}}, in_instr[31:20]};
        dec.src2_sel = 1'b1;
      end
      OpImm, OpImm32: begin
        dec.typ      = TypI;
        imm32        = {{20{in_instr[31]}}, in_instr[31:20]};
        dec.src2_sel = 1'b1;
        dec.alu_op   = f3_op(funct3, in_instr[30] & (funct3 == 3'b101));
        illegal      = shift_bad | ((opcode == OpImm32) && (XLEN == 32));
      end
      OpStore: begin
        dec.typ      = TypS;
        imm32        = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
        dec.src2_sel = 1'b1;
      end
      OpBranch: begin
        dec.typ = TypB;
        imm32   = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
      end
      OpLui, OpAuipc: begin
        dec.typ      = TypU;
        imm32        = {in_instr[31:12], 12'b0};
        dec.src1_sel = (opcode == OpAuipc);
        dec.src2_sel = 1'b1;
        dec.alu_op   = (opcode == OpLui) ? AluPassb : AluAdd;
      end
      OpJal: begin
        dec.typ      = TypJ;
        imm32        = {{12{in_instr[31]}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
        dec.src1_sel = 1'b1;
        dec.src2_sel = 1'b1;
      end
      OpSystem: illegal = !dec.ebreak;
      default:  illegal = 1'b1;
    endcase
    dec.imm  = XLEN'($signed(imm32));
    dec.word = (opcode == OpImm32) || (opcode == OpReg32);
    if (illegal) begin
      dec.typ      = '0;
      dec.imm      = '0;
      dec.alu_op   = AluAdd;
      dec.src1_sel = 1'b0;
      dec.src2_sel = 1'b0;
      dec.word     = 1'b0;
    end
    dec.illegal = illegal;
    dec.rf_we   = (|(dec.typ & (TypR | TypI | TypU | TypJ))) && (dec.rd != '0) &&
                  !illegal && !dec.ebreak;
  end

  entry_t main_q, main_d, skid_q, skid_d;
  logic   main_v_q, main_v_d, skid_v_q, skid_v_d;
  logic   accept;

  assign in_ready = ~skid_v_q;
  assign accept   = in_valid & in_ready;

  always_comb begin
    main_d   = main_q;
    skid_d   = skid_q;
    main_v_d = main_v_q;
    skid_v_d = skid_v_q;
    if (flush) begin
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
      main_d   = '0;
    end else if (!main_v_q || out_ready) begin
      if (skid_v_q) begin
        main_d   = skid_q;
        main_v_d = 1'b1;
        skid_v_d = 1'b0;
      end else if (accept) begin
        main_d   = dec;
        main_v_d = 1'b1;
      end else begin
        main_d   = '0;
        main_v_d = 1'b0;
      end
    end else if (accept) begin
      skid_d   = dec;
      skid_v_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q   <= '0;
      skid_q   <= '0;
      main_v_q <= 1'b0;
      skid_v_q <= 1'b0;
    end else begin
      main_q   <= main_d;
      skid_q   <= skid_d;
      main_v_q <= main_v_d;
      skid_v_q <= skid_v_d;
    end
  end

  assign out_valid    = main_v_q;
  assign out_pc       = main_q.pc;
  assign out_type     = main_q.typ;
  assign out_imm      = main_q.imm;
  assign out_rs1      = main_q.rs1;
  assign out_rs2      = main_q.rs2;
  assign out_rd       = main_q.rd;
  assign out_rf_we    = main_q.rf_we;
  assign out_src1_sel = main_q.src1_sel;
  assign out_src2_sel = main_q.src2_sel;
  assign out_alu_op   = main_q.alu_op;
  assign out_word     = main_q.word;
  assign out_illegal  = main_q.illegal;
  assign out_ebreak   = main_q.ebreak;

endmodule

// File: tb/tb_ysyx_22041405_idu_pipe.sv
// Scoreboard bench for the decode stage: XLEN=64 instance under random backpressure,
// plus an XLEN=32 instance for W-op legality.
module tb_ysyx_22041405_idu_pipe;

  typedef struct packed {
    logic [63:0] pc;
    logic [5:0]  typ;
    logic [63:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        rf_we;
    logic        s1;
    logic        s2;
    logic [3:0]  alu;
    logic        word;
    logic        illegal;
    logic        ebreak;
  } exp_t;

  logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] in_instr = '0;
  logic [63:0] in_pc = '0;
  logic        in_ready, out_valid, out_rf_we, out_src1_sel, out_src2_sel;
  logic        out_word, out_illegal, out_ebreak;
  logic [63:0] out_pc, out_imm;
  logic [5:0]  out_type;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic [3:0]  out_alu_op;

  logic        s_flush = 1'b0, s_in_valid = 1'b0, s_out_ready = 1'b1;
  logic [31:0] s_in_instr = '0, s_in_pc = '0;
  logic        s_in_ready, s_out_valid, s_out_rf_we, s_out_src1_sel, s_out_src2_sel;
  logic        s_out_word, s_out_illegal, s_out_ebreak;
  logic [31:0] s_out_pc, s_out_imm;
  logic [5:0]  s_out_type;
  logic [4:0]  s_out_rs1, s_out_rs2, s_out_rd;
  logic [3:0]  s_out_alu_op;

  exp_t q[$];
  int   n_checks = 0, n_fail = 0;
  int   rmode = 0;  // 0: out_ready low, 1: high, 2: random

  ysyx_22041405_idu_pipe #(.XLEN(64), .ADDR_WIDTH(5)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_type(out_type), .out_imm(out_imm), .out_rs1(out_rs1),
    .out_rs2(out_rs2), .out_rd(out_rd), .out_rf_we(out_rf_we), .out_src1_sel(out_src1_sel),
    .out_src2_sel(out_src2_sel), .out_alu_op(out_alu_op), .out_word(out_word),
    .out_illegal(out_illegal), .out_ebreak(out_ebreak)
  );

  ysyx_22041405_idu_pipe #(.XLEN(32), .ADDR_WIDTH(5)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(s_flush), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_instr(s_in_instr), .in_pc(s_in_pc), .out_valid(s_out_valid), .out_ready(s_out_ready),
    .out_pc(s_out_pc), .out_type(s_out_type), .out_imm(s_out_imm), .out_rs1(s_out_rs1),
    .out_rs2(s_out_rs2), .out_rd(s_out_rd), .out_rf_we(s_out_rf_we),
    .out_src1_sel(s_out_src1_sel), .out_src2_sel(s_out_src2_sel), .out_alu_op(s_out_alu_op),
    .out_word(s_out_word), .out_illegal(s_out_illegal), .out_ebreak(s_out_ebreak)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #2;
    if (rmode == 2) out_ready = 1'($urandom_range(0, 1));
    else out_ready = (rmode == 1);
  end

  task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic chk_entry(string tag, exp_t g, exp_t e);
    chk({tag, "_pc"}, g.pc, e.pc);
    chk({tag, "_type"}, 64'(g.typ), 64'(e.typ));
    chk({tag, "_imm"}, g.imm, e.imm);
    chk({tag, "_regs"}, 64'({g.rs1, g.rs2, g.rd}), 64'({e.rs1, e.rs2, e.rd}));
    chk({tag, "_ctrl"}, 64'({g.rf_we, g.s1, g.s2, g.alu, g.word, g.illegal, g.ebreak}),
        64'({e.rf_we, e.s1, e.s2, e.alu, e.word, e.illegal, e.ebreak}));
  endtask

  // Reference decode built from the ISA field rules with plain arithmetic
  function automatic exp_t model(logic [31:0] ins, logic [63:0] pc, int xl);
    exp_t e;
    int signed s;
    longint imm;
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [11:0] upper;
    bit ill;
    int shw;
    int alu_tab[8];
    alu_tab = '{0, 2, 3, 4, 5, 6, 8, 9};
    e = '0;
    s = ins;
    op = ins[6:0];
    f3 = ins[14:12];
    f7 = ins[31:25];
    e.pc = pc;
    e.rs1 = ins[19:15];
    e.rs2 = ins[24:20];
    e.rd = ins[11:7];
    imm = 0;
    ill = 0;
    if (ins == 32'h0010_0073) begin
      e.ebreak = 1;
    end else if (op == 7'b0110011 || op == 7'b0111011) begin
      e.typ = 6'b100000;
      e.alu = 4'(alu_tab[f3]);
      if (f7[5] && f3 == 0) e.alu = 4'd1;
      if (f7[5] && f3 == 5) e.alu = 4'd7;
      ill = !(f7 == 0 || (f7 == 7'h20 && (f3 == 0 || f3 == 5))) || (op[3] && xl == 32);
      e.word = op[3];
    end else if (op inside {7'b0000011, 7'b0010011, 7'b0011011, 7'b1100111}) begin
      e.typ = 6'b010000;
      imm = longint'(s >>> 20);
      e.s2 = 1;
      if (op == 7'b0010011 || op == 7'b0011011) begin
        e.alu = 4'(alu_tab[f3]);
        e.word = op[3];
        ill = op[3] && xl == 32;
        if (f3 == 1 || f3 == 5) begin
          shw = (op == 7'b0010011 && xl == 64) ? 6 : 5;
          upper = ins[31:20] >> shw;
          if (f3 == 5 && ins[30]) begin
            e.alu = 4'd7;
            upper = upper ^ (12'd1 << (10 - shw));
          end
          if (upper != 0) ill = 1;
        end
      end
    end else if (op == 7'b0100011) begin
      e.typ = 6'b001000;
      imm = (longint'(s >>> 25) <<< 5) | longint'(ins[11:7]);
      e.s2 = 1;
    end else if (op == 7'b1100011) begin
      e.typ = 6'b000100;
      imm = (longint'(s >>> 31) <<< 12) | (longint'(ins[7]) << 11) |
            (longint'(ins[30:25]) << 5) | (longint'(ins[11:8]) << 1);
    end else if (op == 7'b0110111 || op == 7'b0010111) begin
      e.typ = 6'b000010;
      imm = longint'(s) & ~longint'(4095);
      e.s2 = 1;
      e.s1 = (op == 7'b0010111);
      e.alu = (op == 7'b0110111) ? 4'd10 : 4'd0;
    end else if (op == 7'b1101111) begin
      e.typ = 6'b000001;
      imm = (longint'(s >>> 31) <<< 20) | (longint'(ins[19:12]) << 12) |
            (longint'(ins[20]) << 11) | (longint'(ins[30:21]) << 1);
      e.s1 = 1;
      e.s2 = 1;
    end else begin
      ill = 1;
    end
    if (ill) begin
      e.typ = 0; imm = 0; e.alu = 0; e.s1 = 0; e.s2 = 0; e.word = 0;
    end
    e.illegal = ill;
    e.imm = imm;
    if (xl == 32) begin
      e.imm = {32'b0, e.imm[31:0]};
      e.pc = {32'b0, pc[31:0]};
    end
    e.rf_we = ((e.typ & 6'b110011) != 0) && (e.rd != 0) && !ill && !e.ebreak;
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0] ops[14];
    logic [31:0] ins;
    ops = '{7'b0110011, 7'b0111011, 7'b0000011, 7'b0010011, 7'b0011011, 7'b1100111,
            7'b0100011, 7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b1110011,
            7'b0000000, 7'b1111111};
    ins = $urandom;
    ins[6:0] = ops[$urandom_range(0, 13)];
    case ($urandom_range(0, 3))
      0: ins[31:25] = 7'h00;
      1: ins[31:25] = 7'h20;
      2: ins[31:26] = 6'h00;
      default: ;
    endcase
    if ($urandom_range(0, 15) == 0) ins = 32'h0010_0073;
    return ins;
  endfunction

  function automatic exp_t grab64();
    exp_t g;
    g.pc = out_pc; g.typ = out_type; g.imm = out_imm;
    g.rs1 = out_rs1; g.rs2 = out_rs2; g.rd = out_rd;
    g.rf_we = out_rf_we; g.s1 = out_src1_sel; g.s2 = out_src2_sel; g.alu = out_alu_op;
    g.word = out_word; g.illegal = out_illegal; g.ebreak = out_ebreak;
    return g;
  endfunction

  function automatic exp_t grab32();
    exp_t g;
    g.pc = {32'b0, s_out_pc}; g.typ = s_out_type; g.imm = {32'b0, s_out_imm};
    g.rs1 = s_out_rs1; g.rs2 = s_out_rs2; g.rd = s_out_rd;
    g.rf_we = s_out_rf_we; g.s1 = s_out_src1_sel; g.s2 = s_out_src2_sel; g.alu = s_out_alu_op;
    g.word = s_out_word; g.illegal = s_out_illegal; g.ebreak = s_out_ebreak;
    return g;
  endfunction

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: got pc %h, expected no output", out_pc);
      end else begin
        chk_entry("mon", grab64(), q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(logic [31:0] ins, logic [63:0] pc);
    bit acc = 0;
    in_instr = ins;
    in_pc = pc;
    in_valid = 1'b1;
    for (int i = 0; i < 100 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
    end
    if (acc) q.push_back(model(ins, pc, 64));
    else begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: got no acceptance for pc %h, expected within 100 cycles", pc);
    end
    #1 in_valid = 1'b0;
  endtask

  task automatic drain(string name);
    for (int i = 0; i < 200 && q.size() > 0; i++) tick();
    chk(name, 64'(q.size()), 0);
  endtask

  task automatic s_issue(logic [31:0] ins, logic [31:0] pc);
    s_in_instr = ins;
    s_in_pc = pc;
    s_in_valid = 1'b1;
    chk("x32_in_ready", 64'(s_in_ready), 1);
    tick();
    s_in_valid = 1'b0;
    chk("x32_valid", 64'(s_out_valid), 1);
    chk_entry("x32", grab32(), model(ins, {32'b0, pc}, 32));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit i2_done = 0;
    repeat (2) tick();
    chk("rst_out_valid", 64'(out_valid), 0);
    chk("rst_in_ready", 64'(in_ready), 1);
    chk("rst_pc", out_pc, 0);
    chk("rst_imm", out_imm, 0);
    chk("rst_ctrl", 64'({out_type, out_rs1, out_rs2, out_rd, out_rf_we, out_src1_sel,
                         out_src2_sel, out_alu_op, out_word, out_illegal, out_ebreak}), 0);
    rst_n = 1'b1;
    tick();

    rmode = 1;
    send(32'hFFF0_0093, 64'h1000);
    chk("addi_valid", 64'(out_valid), 1);
    chk("addi_type", 64'(out_type), 64'b010000);
    chk("addi_imm", out_imm, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("addi_ctrl", 64'({out_rf_we, out_alu_op, out_src2_sel}), 64'({1'b1, 4'd0, 1'b1}));
    send(32'h8000_0137, 64'h1004);
    chk("lui_imm", out_imm, 64'hFFFF_FFFF_8000_0000);
    chk("lui_alu", 64'(out_alu_op), 10);
    chk("lui_type", 64'(out_type), 64'b000010);
    drain("drain_directed");

    // Backpressure: two accepted, third stalls until release
    rmode = 0;
    tick();
    send(rand_instr(), 64'h2000);
    send(rand_instr(), 64'h2004);
    chk("bp_in_ready_low", 64'(in_ready), 0);
    fork
      begin
        send(rand_instr(), 64'h2008);
        i2_done = 1;
      end
    join_none
    repeat (3) tick();
    chk("bp_hold_valid", 64'(out_valid), 1);
    chk("bp_hold_pc", out_pc, 64'h2000);
    chk("bp_still_stalled", 64'(in_ready), 0);
    rmode = 1;
    for (int i = 0; i < 50 && !i2_done; i++) tick();
    chk("bp_third_accepted", 64'(i2_done), 1);
    drain("drain_bp");

    // Flush with main and skid full
    rmode = 0;
    tick();
    send(rand_instr(), 64'h3000);
    send(rand_instr(), 64'h3004);
    in_instr = 32'hFFF0_0093;
    in_pc = 64'hDEAD_0000;
    in_valid = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    q.delete();
    chk("flush_full_valid", 64'(out_valid), 0);
    chk("flush_full_ready", 64'(in_ready), 1);
    // Flush with only main full: the offered input must be dropped
    send(rand_instr(), 64'h3100);
    in_instr = 32'hFFF0_0093;
    in_pc = 64'hDEAD_0004;
    in_valid = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    q.delete();
    chk("flush_main_valid", 64'(out_valid), 0);
    rmode = 1;
    send(32'h8000_0137, 64'h3200);
    drain("drain_flush");

    rmode = 2;
    for (int i = 0; i < 300; i++) begin
      send(rand_instr(), {$urandom, $urandom} & ~64'h3);
      if ($urandom_range(0, 3) == 0) tick();
    end
    rmode = 1;
    drain("drain_random");

    // Asynchronous reset while entries are stalled
    rmode = 0;
    tick();
    send(rand_instr(), 64'h4000);
    send(rand_instr(), 64'h4004);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(out_valid), 0);
    chk("arst_ready", 64'(in_ready), 1);
    q.delete();
    #3 rst_n = 1'b1;
    tick();
    chk("arst_post_ready", 64'(in_ready), 1);
    chk("arst_post_pc", out_pc, 0);
    chk("arst_post_ctrl", 64'({out_valid, out_type, out_imm[31:0], out_rd, out_rf_we,
                               out_alu_op, out_illegal, out_ebreak}), 0);

    s_issue(32'h0010_009B, 32'h100);
    chk("addiw32_illegal", 64'(s_out_illegal), 1);
    chk("addiw32_rf_we", 64'(s_out_rf_we), 0);
    s_issue(32'h0010_0073, 32'h104);
    chk("ebreak32_flag", 64'(s_out_ebreak), 1);
    chk("ebreak32_illegal", 64'(s_out_illegal), 0);
    for (int i = 0; i < 200; i++) s_issue(rand_instr(), $urandom & ~32'h3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_22041405_idu_pipe.md
Name: ysyx_22041405_idu_pipe

Overview:
- Registered RV32I/RV64I decode stage sitting between IFU and EXU in the NPC core.
- Decodes the 32-bit instruction into type, register addresses, sign-extended immediate and ALU controls.
- Uses a valid/ready handshake with a 2-entry skid buffer so that EXU backpressure never drops an instruction.
- Generalises the single-cycle combinational decoder: parametrised XLEN, W-op support, illegal/ebreak detection, flush.

Parameters:
- XLEN, 64, datapath width (32 or 64); immediates and PC sized to it.
- ADDR_WIDTH, 5, register address width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous squash of all buffered entries.
- in_valid  in  1  IFU has an instruction.
- in_ready  out  1  stage can accept an instruction.
- in_instr  in  32  instruction word.
- in_pc  in  XLEN  instruction PC.
- out_valid  out  1  decoded entry valid.
- out_ready  in  1  EXU accepts the entry.
- out_pc  out  XLEN  PC of the entry.
- out_type  out  6  one-hot {R,I,S,B,U,J}; all zero for SYSTEM or illegal.
- out_imm  out  XLEN  sign-extended immediate for the type; 0 for R.
- out_rs1, out_rs2, out_rd  out  ADDR_WIDTH  instr[19:15], [24:20], [11:7].
- out_rf_we  out  1  register write enable.
- out_src1_sel  out  1  0 = rs1, 1 = PC (AUIPC, JAL).
- out_src2_sel  out  1  0 = rs2, 1 = imm.
- out_alu_op  out  4  ALU operation code.
- out_word  out  1  RV64 W-op (opcodes 0011011/0111011); result is sign-extended from 32 bits.
- out_illegal  out  1  undecodable instruction.
- out_ebreak  out  1  instruction == 32'h00100073.

Behaviour:
- Reset: all out_* = 0; in_ready = 1; both buffer entries invalid. Reset is asynchronous and may hit mid-transfer; any partially held entry is discarded.
- Transfer rules:
  - Input transfer when in_valid & in_ready at a rising edge.
  - Output transfer when out_valid & out_ready.
  - Latency: an instruction accepted at edge N is presented with out_valid = 1 after edge N.
- Buffer:
  - Main register drives the outputs; the skid register holds one extra entry.
  - in_ready = !skid_valid, registered (no combinational path from out_ready).
  - If main is valid and not taken, a new input goes to skid.
  - When main is taken, skid (if valid) moves into main, else the new input does, else main clears.
  - Order is strictly FIFO; throughput is 1 per cycle when out_ready stays 1.
- Flush: at the edge, main and skid are invalidated and the input that cycle is not accepted. out_valid = 0 and in_ready = 1 next cycle. Flush has priority over all other events.
- Decode is combinational on in_instr and registered on capture.
  - Immediates, sign-extended from bit 31:
    - I: [31:20]
    - S: {[31:25],[11:7]}
    - B: {[31],[7],[30:25],[11:8],0}
    - U: {[31:12],12'b0}
    - J: {[31],[19:12],[20],[30:21],0}
  - Type map:
    - R: 0110011, 0111011
    - I: 0000011, 0010011, 0011011, 1100111
    - S: 0100011
    - B: 1100011
    - U: 0110111, 0010111
    - J: 1101111
- ALU op encoding: ADD 0, SUB 1, SLL 2, SLT 3, SLTU 4, XOR 5, SRL 6, SRA 7, OR 8, AND 9, PASSB 10.
  - LUI = PASSB.
  - Loads, stores, AUIPC, JAL, JALR and branches = ADD.
  - R/I arithmetic is mapped from func3, with func7[5] selecting SUB or SRA.
- out_rf_we = 1 for R, I, U and J types, except when rd = 0, illegal, or ebreak.
- Illegal when any of the following holds:
  - unknown opcode;
  - SYSTEM opcode other than ebreak;
  - R func7 not 0000000/0100000, or 0100000 with func3 not 000/101;
  - W opcodes when XLEN = 32;
  - shift-immediate with func7 bits above the shamt field nonzero (shamt is 5 bits at XLEN 32, 6 bits at XLEN 64).
- Illegal entries still flow through the handshake with out_illegal = 1 and out_type = 0.

Test Plan:
- XLEN=64, addi x1,x0,-1 (32'hFFF00093) -> out_type = 6'b010000, out_imm = 64'hFFFF_FFFF_FFFF_FFFF, out_rf_we = 1, out_alu_op = 0, out_src2_sel = 1, one cycle after acceptance.
- XLEN=64, lui x2,0x80000 (32'h80000137) -> out_imm = 64'hFFFF_FFFF_8000_0000, out_alu_op = 10, out_type = U.
- Backpressure: hold out_ready = 0 and push 3 instructions -> first two accepted, in_ready = 0 from the edge after the 2nd; release -> order I0, I1, I2 with no drop or duplication.
- flush with main and skid full and in_valid = 1 -> next cycle out_valid = 0, in_ready = 1; the flushed instruction never appears.
- XLEN=32, addiw (32'h0010009B) -> out_illegal = 1, out_rf_we = 0; 32'h00100073 -> out_ebreak = 1, out_illegal = 0.
- rst_n asserted while an entry is stalled -> out_valid falls immediately (asynchronously); after release in_ready = 1 and all outputs read 0.
